// File: rtl/pss_tx_pkg.sv
// rtl/pss_tx_pkg.sv - shared types and width helpers for the PSS/CP transmit framer
package pss_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        EMIT_CP   = 2'd2,
        EMIT_BODY = 2'd3
    } state_t;

    localparam int SYM_CNT_W = 4;

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cp_symbol_buffer.sv
// rtl/cp_symbol_buffer.sv - one-symbol simple dual-port sample RAM with registered, stallable read
module cp_symbol_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pss_cp_inserter_tx.sv
// rtl/pss_cp_inserter_tx.sv - OFDM symbol framer: buffers IFFT symbols, prepends CP, substitutes PSS symbol
module pss_cp_inserter_tx
    import pss_tx_pkg::*;
#(
    parameter int                         IN_DW          = 32,
    parameter int                         FFT_LEN        = 256,
    parameter int                         CP_LEN         = 18,
    parameter int                         SYMS_PER_FRAME = 14,
    parameter int                         PSS_SYM_IDX    = 2,
    parameter logic [FFT_LEN*IN_DW-1:0]   PSS_TIME       = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [IN_DW-1:0]     s_axis_in_tdata,
    input  logic                 s_axis_in_tvalid,
    output logic                 s_axis_in_tready,
    input  logic                 s_axis_in_tlast,
    output logic [IN_DW-1:0]     m_axis_out_tdata,
    output logic                 m_axis_out_tvalid,
    input  logic                 m_axis_out_tready,
    output logic                 m_axis_out_tlast,
    output logic [SYM_CNT_W-1:0] symbol_idx_o,
    output logic                 pss_active_o,
    output logic                 frame_start_o,
    output logic                 error_o
);

    localparam int ADDR_W = cnt_width(FFT_LEN);
    localparam int TOT    = FFT_LEN + CP_LEN;
    localparam int CNT_W  = cnt_width(TOT + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [SYM_CNT_W-1:0] idx_q, idx_d;
    logic                 err_q, err_d;

    logic                 v1_q, l1_q, v2_q, l2_q;
    logic [IN_DW-1:0]     d2_q, pss_rd_q, ram_rd_data;
    logic [IN_DW-1:0]     pss_rom [FFT_LEN];

    logic                 is_pss, in_hs, out_hs, rd_phase, rd_en, s2_load;
    logic                 last_body, last_cp;
    logic [ADDR_W-1:0]    rd_addr;

    for (genvar k = 0; k < FFT_LEN; k++) begin : g_pss_rom
        assign pss_rom[k] = PSS_TIME[k*IN_DW +: IN_DW];
    end

    assign is_pss    = (idx_q == SYM_CNT_W'(PSS_SYM_IDX));
    assign in_hs     = s_axis_in_tvalid && s_axis_in_tready;
    assign out_hs    = v2_q && m_axis_out_tready;
    assign last_body = (cnt_q == CNT_W'(FFT_LEN - 1));
    assign last_cp   = (cnt_q == CNT_W'(CP_LEN - 1));

    // Read k of a symbol maps to sample (k - CP_LEN) mod FFT_LEN, which covers CP then body
    assign rd_addr = rd_cnt_q[ADDR_W-1:0] + ADDR_W'(FFT_LEN - CP_LEN);
    assign s2_load = v1_q && (!v2_q || m_axis_out_tready);
    assign rd_en   = rd_phase && (rd_cnt_q < CNT_W'(TOT)) && (!v1_q || s2_load);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = is_pss ? EMIT_CP : FILL;
            FILL:      if (in_hs && last_body) state_d = EMIT_CP;
            EMIT_CP:   if (out_hs && last_cp) state_d = EMIT_BODY;
            EMIT_BODY: if (out_hs && last_body) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The PSS symbol starts reading from ROM already in IDLE to meet its two-cycle latency
    always_comb begin
        s_axis_in_tready = 1'b0;
        rd_phase         = 1'b0;
        case (state_q)
            IDLE:      rd_phase = is_pss;
            FILL:      s_axis_in_tready = 1'b1;
            EMIT_CP:   rd_phase = 1'b1;
            EMIT_BODY: rd_phase = 1'b1;
            default:   rd_phase = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        rd_cnt_d = rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
        case (state_q)
            IDLE: cnt_d = '0;
            FILL: begin
                if (in_hs) begin
                    cnt_d = last_body ? '0 : cnt_q + 1'b1;
                    if (s_axis_in_tlast != last_body) begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT_CP: begin
                if (out_hs) begin
                    cnt_d = last_cp ? '0 : cnt_q + 1'b1;
                end
            end
            EMIT_BODY: begin
                if (out_hs) begin
                    cnt_d = last_body ? '0 : cnt_q + 1'b1;
                    if (last_body) begin
                        rd_cnt_d = '0;
                        idx_d    = (idx_q == SYM_CNT_W'(SYMS_PER_FRAME - 1)) ? '0 : idx_q + 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            v1_q     <= 1'b0;
            l1_q     <= 1'b0;
            v2_q     <= 1'b0;
            l2_q     <= 1'b0;
            d2_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            if (rd_en) begin
                v1_q <= 1'b1;
                l1_q <= (rd_cnt_q == CNT_W'(TOT - 1));
            end else if (s2_load) begin
                v1_q <= 1'b0;
            end
            if (s2_load) begin
                v2_q <= 1'b1;
                l2_q <= l1_q;
                d2_q <= is_pss ? pss_rd_q : ram_rd_data;
            end else if (m_axis_out_tready) begin
                v2_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            pss_rd_q <= pss_rom[rd_addr];
        end
    end

    cp_symbol_buffer #(
        .DW    (IN_DW),
        .DEPTH (FFT_LEN),
        .AW    (ADDR_W)
    ) u_buf (
        .clk_i     (clk_i),
        .wr_en_i   (in_hs),
        .wr_addr_i (cnt_q[ADDR_W-1:0]),
        .wr_data_i (s_axis_in_tdata),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rd_data)
    );

    assign m_axis_out_tdata  = d2_q;
    assign m_axis_out_tvalid = v2_q;
    assign m_axis_out_tlast  = l2_q;
    assign symbol_idx_o      = idx_q;
    assign pss_active_o      = v2_q && is_pss;
    assign frame_start_o     = out_hs && (state_q == EMIT_CP) && (cnt_q == '0) && (idx_q == '0);
    assign error_o           = err_q;

endmodule

// File: tb/tb_pss_cp_inserter_tx.sv
// tb/tb_pss_cp_inserter_tx.sv - randomized self-checking bench for pss_cp_inserter_tx
module tb_pss_cp_inserter_tx;

    localparam int DW   = 32;
    localparam int FFT  = 256;
    localparam int CP   = 18;
    localparam int SPF  = 14;
    localparam int PSSI = 2;

    function automatic logic [FFT*DW-1:0] gen_pss();
        logic [FFT*DW-1:0] r;
        r = '0;
        for (int k = 0; k < FFT; k++) begin
            r[k*DW +: DW] = 32'hC0DE_0000 + 32'(k * 7);
        end
        return r;
    endfunction

    localparam logic [FFT*DW-1:0] PSS_C = gen_pss();

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [DW-1:0] s_axis_in_tdata = '0;
    logic          s_axis_in_tvalid = 1'b0;
    logic          s_axis_in_tready;
    logic          s_axis_in_tlast = 1'b0;
    logic [DW-1:0] m_axis_out_tdata;
    logic          m_axis_out_tvalid;
    logic          m_axis_out_tready = 1'b1;
    logic          m_axis_out_tlast;
    logic [3:0]    symbol_idx_o;
    logic          pss_active_o;
    logic          frame_start_o;
    logic          error_o;

    pss_cp_inserter_tx #(
        .IN_DW(DW), .FFT_LEN(FFT), .CP_LEN(CP), .SYMS_PER_FRAME(SPF),
        .PSS_SYM_IDX(PSSI), .PSS_TIME(PSS_C)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
        .s_axis_in_tready(s_axis_in_tready), .s_axis_in_tlast(s_axis_in_tlast),
        .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
        .m_axis_out_tready(m_axis_out_tready), .m_axis_out_tlast(m_axis_out_tlast),
        .symbol_idx_o(symbol_idx_o), .pss_active_o(pss_active_o),
        .frame_start_o(frame_start_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        pss;
        logic [3:0]  idx;
        logic        fs;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_in_cyc = 0;
    int          last_out_cyc = 0;
    int          sym_n = 0;
    int          beats = 0;
    int          fs_cnt = 0;
    bit          mon_en = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          sym_started = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push_symbol(input logic [31:0] sym [FFT], input bit pss, input int sidx);
        exp_t e;
        for (int j = 0; j < CP + FFT; j++) begin
            e.data = (j < CP) ? sym[FFT - CP + j] : sym[j - CP];
            e.last = (j == CP + FFT - 1);
            e.pss  = pss;
            e.idx  = 4'(sidx);
            e.fs   = (sidx == 0) && (j == 0);
            expq.push_back(e);
        end
    endtask

    task automatic run_symbols(input int count, input bit ramp_first, input int bad_sidx);
        logic [31:0] sym [FFT];
        int sidx, j, guard;
        bit bad;
        for (int s = 0; s < count; s++) begin
            sidx = sym_n % SPF;
            if (sidx == PSSI) begin
                for (int k = 0; k < FFT; k++) sym[k] = PSS_C[k*DW +: DW];
                push_symbol(sym, 1'b1, sidx);
            end else begin
                bad = (sidx == bad_sidx);
                for (int k = 0; k < FFT; k++) sym[k] = (ramp_first && s == 0) ? 32'(k) : $urandom;
                push_symbol(sym, 1'b0, sidx);
                j = 0;
                guard = 0;
                while (j < FFT && guard < 20000) begin
                    @(negedge clk_i);
                    s_axis_in_tvalid = ($urandom_range(0, 3) != 0);
                    s_axis_in_tdata  = sym[j];
                    s_axis_in_tlast  = bad ? (j == 100) : (j == FFT - 1);
                    #1;
                    if (s_axis_in_tvalid && s_axis_in_tready) begin
                        j++;
                        last_in_cyc = cyc + 1;
                    end
                    guard++;
                end
                if (j < FFT) check_eq("fill_timeout", j, FFT);
                @(negedge clk_i);
                s_axis_in_tvalid = 1'b0;
                s_axis_in_tlast  = 1'b0;
            end
            sym_n++;
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (expq.size() != 0 && guard < 20000) begin
            @(negedge clk_i);
            guard++;
        end
        check_eq("drain", expq.size(), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            m_axis_out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (mon_en) begin
                if (hold_pending) begin
                    check_eq("hold_valid", m_axis_out_tvalid, 1);
                    check_eq("hold_data", m_axis_out_tdata, held_data);
                    check_eq("hold_last", m_axis_out_tlast, held_last);
                end
                if (m_axis_out_tvalid && !sym_started && expq.size() != 0) begin
                    sym_started = 1'b1;
                    if (expq[0].pss) check_eq("pss_latency", cyc - last_out_cyc, 2);
                    else             check_eq("data_latency", cyc - last_in_cyc, 2);
                end
                if (m_axis_out_tvalid && m_axis_out_tready) begin
                    if (expq.size() == 0) begin
                        check_eq("unexpected_beat", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check_eq("data", m_axis_out_tdata, e.data);
                        check_eq("tlast", m_axis_out_tlast, e.last);
                        check_eq("pss_active", pss_active_o, e.pss);
                        check_eq("symbol_idx", symbol_idx_o, e.idx);
                        check_eq("frame_start", frame_start_o, e.fs);
                        if (e.pss) check_eq("pss_in_tready", s_axis_in_tready, 0);
                    end
                    if (frame_start_o) fs_cnt++;
                    beats++;
                    if (m_axis_out_tlast) begin
                        check_eq("beats_per_symbol", beats, CP + FFT);
                        beats = 0;
                        sym_started = 1'b0;
                        last_out_cyc = cyc + 1;
                    end
                end else begin
                    check_eq("frame_start_quiet", frame_start_o, 0);
                end
                hold_pending = m_axis_out_tvalid && !m_axis_out_tready;
                held_data    = m_axis_out_tdata;
                held_last    = m_axis_out_tlast;
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk_i);
        #2;
        check_eq("rst_tvalid", m_axis_out_tvalid, 0);
        check_eq("rst_tdata", m_axis_out_tdata, 0);
        check_eq("rst_idx", symbol_idx_o, 0);
        check_eq("rst_error", error_o, 0);
        check_eq("rst_tready", s_axis_in_tready, 0);
        check_eq("rst_pss", pss_active_o, 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        #2;
        check_eq("fill_after_reset", s_axis_in_tready, 1);
        mon_en = 1'b1;

        rdy_rand = 1'b0;
        run_symbols(15, 1'b1, -1);
        wait_drain();
        check_eq("frame_start_count", fs_cnt, 2);
        check_eq("idx_after_15", symbol_idx_o, 1);
        check_eq("error_clean", error_o, 0);

        rdy_rand = 1'b1;
        run_symbols(14, 1'b0, 5);
        wait_drain();
        check_eq("error_sticky", error_o, 1);
        check_eq("idx_after_29", symbol_idx_o, 1);

        rdy_rand = 1'b0;
        run_symbols(1, 1'b0, -1);
        guard = 0;
        while (beats < CP + 50 && guard < 5000) begin
            @(negedge clk_i);
            #2;
            guard++;
        end
        check_eq("reach_body_50", beats, CP + 50);
        reset_i = 1'b1;
        mon_en  = 1'b0;
        @(negedge clk_i);
        #2;
        check_eq("midrst_tvalid", m_axis_out_tvalid, 0);
        check_eq("midrst_idx", symbol_idx_o, 0);
        check_eq("midrst_error", error_o, 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        #2;
        check_eq("midrst_refill", s_axis_in_tready, 1);
        expq.delete();
        beats = 0;
        fs_cnt = 0;
        sym_n = 0;
        sym_started = 1'b0;
        hold_pending = 1'b0;
        mon_en = 1'b1;
        run_symbols(1, 1'b1, -1);
        wait_drain();
        check_eq("post_rst_fs", fs_cnt, 1);
        check_eq("post_rst_error", error_o, 0);
        check_eq("post_rst_idx", symbol_idx_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
